textlcd_axil_slave: RTL and testbench

- AXI4-Lite responder for the text-LCD IP. It sits between the PS/BFM master and the character-LCD pins.
- Holds four 32-bit read/write registers plus one read-only status register.
- A write to register 0 launches one timed LCD bus cycle (RS, RW, 8-bit data, E strobe) through an internal sequencer.

---
 rtl/textlcd_axil_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_textlcd_axil_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/textlcd_axil_slave.sv
// AXI4-Lite register block driving a character-LCD bus through a timed E-strobe sequencer.
// Build option TEXTLCD_BUSY_STALL_EN: REG0 launches while busy stall the write response instead of flagging overrun.
module textlcd_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int T_SETUP            = 4,
  parameter int T_PULSE            = 12,
  parameter int T_HOLD             = 12
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              LCD_RS,
  output logic                              LCD_RW,
  output logic                              LCD_E,
  output logic [7:0]                        LCD_DB,
  output logic                              LCD_BUSY
);

  localparam int NB   = C_S_AXI_DATA_WIDTH / 8;
  localparam int TMAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                            : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
  localparam int CW   = $clog2(TMAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} seq_state_t;

  logic                          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic                          aw_done, w_done;
  logic [2:0]                    awidx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [NB-1:0]                 wstrb_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic                          overrun_q, parity_q;

  logic                          aw_fire, w_fire, ar_fire;
  logic [2:0]                    wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data, wr_old, wr_merged, rd_mux;
  logic [NB-1:0]                 wr_strb;
  logic                          wr_reg0, launch_req, wr_stall, wr_commit, launch, overrun_set;

  seq_state_t                    state, state_nxt;
  logic [CW-1:0]                 cnt, cnt_nxt;
  logic                          e_q, busy_q, e_nxt, busy_nxt, rs_q;
  logic [7:0]                    db_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_fire = S_AXI_AWVALID && awready_q;
  assign w_fire  = S_AXI_WVALID && wready_q;
  assign ar_fire = S_AXI_ARVALID && arready_q;

  // Live channel values are used on their handshake cycle so a same-cycle AW+W commits immediately.
  assign wr_idx     = aw_fire ? S_AXI_AWADDR[4:2] : awidx_q;
  assign wr_data    = w_fire ? S_AXI_WDATA : wdata_q;
  assign wr_strb    = w_fire ? S_AXI_WSTRB : wstrb_q;
  assign wr_reg0    = (wr_idx == 3'd0);
  assign launch_req = wr_reg0 && (wr_strb[0] || wr_strb[1]);

`ifdef TEXTLCD_BUSY_STALL_EN
  assign wr_stall = launch_req && (state != S_IDLE);
`else
  assign wr_stall = 1'b0;
`endif

  assign wr_commit   = (aw_done || aw_fire) && (w_done || w_fire) && !wr_stall;
  assign launch      = wr_commit && launch_req && (state == S_IDLE);
  assign overrun_set = wr_commit && launch_req && (state != S_IDLE);

  always_comb begin
    wr_old = '0;
    if (!wr_idx[2]) wr_old = regs[wr_idx[1:0]];
    wr_merged = wr_old;
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = regs[S_AXI_ARADDR[3:2]];
      3'd4:                   rd_mux = {{(C_S_AXI_DATA_WIDTH-3){1'b0}}, parity_q, overrun_q, busy_q};
      default:                rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      overrun_q <= 1'b0;
      parity_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID && !awready_q && !aw_done && !bvalid_q;
      wready_q  <= S_AXI_WVALID && !wready_q && !w_done && !bvalid_q;
      if (aw_fire) begin
        aw_done <= 1'b1;
        awidx_q <= S_AXI_AWADDR[4:2];
      end
      if (w_fire) begin
        w_done  <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_commit) begin
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        bvalid_q <= 1'b1;
        if (!wr_idx[2]) regs[wr_idx[1:0]] <= wr_merged;
        if (wr_reg0) parity_q <= ~parity_q;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (overrun_set) overrun_q <= 1'b1;
      else if (wr_commit && wr_reg0 && wr_data[31]) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= S_AXI_ARVALID && !arready_q && !rvalid_q;
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      e_q    <= 1'b0;
      busy_q <= 1'b0;
      db_q   <= '0;
      rs_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      e_q    <= e_nxt;
      busy_q <= busy_nxt;
      if (launch) begin
        db_q <= wr_merged[7:0];
        rs_q <= wr_merged[8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (launch) begin
        state_nxt = S_SETUP;
        cnt_nxt   = CW'(T_SETUP - 1);
      end
      S_SETUP: if (cnt == '0) begin
        state_nxt = S_PULSE;
        cnt_nxt   = CW'(T_PULSE - 1);
      end else cnt_nxt = cnt - CW'(1);
      S_PULSE: if (cnt == '0) begin
        state_nxt = S_HOLD;
        cnt_nxt   = CW'(T_HOLD - 1);
      end else cnt_nxt = cnt - CW'(1);
      S_HOLD: if (cnt == '0) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt - CW'(1);
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode the next state so E and BUSY come straight from flops.
  always_comb begin
    e_nxt    = (state_nxt == S_PULSE);
    busy_nxt = (state_nxt != S_IDLE);
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign LCD_RS        = rs_q;
  assign LCD_RW        = 1'b0;
  assign LCD_E         = e_q;
  assign LCD_DB        = db_q;
  assign LCD_BUSY      = busy_q;

endmodule

// File: tb/tb_textlcd_axil_slave.sv
// Directed self-checking bench for textlcd_axil_slave; honours TEXTLCD_BUSY_STALL_EN when defined.
module tb_textlcd_axil_slave;

  logic        tb_ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        lcd_rs, lcd_rw, lcd_e, lcd_busy;
  logic [7:0]  lcd_db;

  int checks = 0;
  int failures = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  textlcd_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
    .T_SETUP(4), .T_PULSE(12), .T_HOLD(12)
  ) dut (
    .ACLK(tb_ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e), .LCD_DB(lcd_db), .LCD_BUSY(lcd_busy)
  );

  // LCD bus observer: strobe count, edge timestamps, DB/RS captured at E rise, DB/RS changes while busy.
  int ncyc = 0, e_rises = 0, db_glitch = 0;
  int t_busy_rise = 0, t_busy_fall = 0, t_e_rise = 0, t_e_fall = 0, t_bv_rise = 0;
  logic e_p = 1'b0, busy_p = 1'b0, bv_p = 1'b0, rs_p = 1'b0, last_rs = 1'b0;
  logic [7:0] db_p = '0, last_db = '0;

  always @(negedge tb_ACLK) begin
    ncyc   <= ncyc + 1;
    e_p    <= lcd_e;
    busy_p <= lcd_busy;
    bv_p   <= bvalid;
    db_p   <= lcd_db;
    rs_p   <= lcd_rs;
    if (lcd_e && !e_p) begin
      e_rises  <= e_rises + 1;
      t_e_rise <= ncyc;
      last_db  <= lcd_db;
      last_rs  <= lcd_rs;
    end
    if (!lcd_e && e_p) t_e_fall <= ncyc;
    if (lcd_busy && !busy_p) t_busy_rise <= ncyc;
    if (!lcd_busy && busy_p) t_busy_fall <= ncyc;
    if (bvalid && !bv_p) t_bv_rise <= ncyc;
    if (lcd_busy && busy_p && (lcd_db !== db_p || lcd_rs !== rs_p)) db_glitch <= db_glitch + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_delay, output logic [1:0] resp, output int bv_lat,
                           output int bv_cnt, output logic tmo);
    int cyc;
    logic aw_f, w_f, b_f, got;
    cyc = 0; got = 1'b0; resp = 2'b11; bv_lat = -1; bv_cnt = 0;
    awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    while (!got && cyc < 400) begin
      if (cyc == aw_delay) awvalid = 1'b1;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      b_f  = bvalid && bready;
      if (bvalid) begin
        bv_cnt++;
        if (bv_lat < 0) bv_lat = cyc;
      end
      if (b_f) resp = bresp;
      @(posedge tb_ACLK); #1;
      cyc++;
      if (aw_f) awvalid = 1'b0;
      if (w_f) wvalid = 1'b0;
      if (b_f) begin
        got = 1'b1;
        bready = 1'b0;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    tmo = !got;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic tmo);
    int cyc;
    logic ar_f, r_f, got;
    cyc = 0; got = 1'b0; d = 32'hxxxx_xxxx; resp = 2'b11;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!got && cyc < 400) begin
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      if (r_f) begin
        d = rdata;
        resp = rresp;
      end
      @(posedge tb_ACLK); #1;
      cyc++;
      if (ar_f) arvalid = 1'b0;
      if (r_f) begin
        got = 1'b1;
        rready = 1'b0;
      end
    end
    arvalid = 1'b0; rready = 1'b0;
    tmo = !got;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic [1:0] resp;
    int lat, cnt;
    logic tmo;
    axi_write(a, d, s, 0, resp, lat, cnt, tmo);
    check({tag, "_bresp"}, {29'b0, tmo, resp}, 32'h0);
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic [1:0] resp;
    logic tmo;
    axi_read(a, d, resp, tmo);
    check({tag, "_rresp"}, {29'b0, tmo, resp}, 32'h0);
    check({tag, "_rdata"}, d, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (lcd_busy && n < 200) begin
      @(posedge tb_ACLK); #1;
      n++;
    end
    check({tag, "_idle_wait"}, 32'(lcd_busy), 32'h0);
  endtask

  task automatic wait_e_high(input string tag);
    int n;
    n = 0;
    while (!lcd_e && n < 200) begin
      @(posedge tb_ACLK); #1;
      n++;
    end
    check({tag, "_e_wait"}, 32'(lcd_e), 32'h1);
  endtask

  initial begin
    logic [1:0] resp;
    int lat, bvc, e0, g0;
    logic tmo;

    repeat (3) @(posedge tb_ACLK);
    #1;
    check("rst_axi_ctrl", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp}), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_lcd", 32'({lcd_rs, lcd_rw, lcd_e, lcd_db, lcd_busy}), 32'h0);
    ARESET = 1'b0;
    @(posedge tb_ACLK); #1;

    // Four write/read pairs; only the REG0 write launches a cycle.
    e0 = e_rises;
    axi_write(5'h00, 32'h0101FFFF, 4'hF, 0, resp, lat, bvc, tmo);
    check("w0_bresp", {29'b0, tmo, resp}, 32'h0);
    check("w0_latency", 32'(lat), 32'd2);
    rd_chk(5'h00, 32'h0101FFFF, "r0");
    wr(5'h04, 32'hABCD0001, 4'hF, "w1");
    rd_chk(5'h04, 32'hABCD0001, "r1");
    wr(5'h08, 32'hDEAD0011, 4'hF, "w2");
    rd_chk(5'h08, 32'hDEAD0011, "r2");
    wr(5'h0C, 32'hBEEF0011, 4'hF, "w3");
    rd_chk(5'h0C, 32'hBEEF0011, "r3");
    wait_idle("s1");
    check("s1_lcd_cycles", 32'(e_rises - e0), 32'd1);
    check("s1_db", 32'(last_db), 32'hFF);
    check("s1_rs", 32'(last_rs), 32'h1);
    rd_chk(5'h10, 32'h4, "s1_status");

    // Timed cycle with DB=0x41, then a second REG0 write during the E pulse.
    e0 = e_rises;
    g0 = db_glitch;
    wr(5'h00, 32'h00000141, 4'hF, "w141");
    rd_chk(5'h10, 32'h1, "status_busy");
    wait_e_high("s2");
    wr(5'h00, 32'h00000022, 4'hF, "w22");
`ifdef TEXTLCD_BUSY_STALL_EN
    check("stall_bv_after_busy_fall", 32'(t_bv_rise - t_busy_fall), 32'd1);
    check("stall_db_new", 32'(lcd_db), 32'h22);
    rd_chk(5'h10, 32'h5, "stall_status");
`else
    check("ovr_db_held", 32'(lcd_db), 32'h41);
    rd_chk(5'h10, 32'h7, "ovr_status");
`endif
    rd_chk(5'h00, 32'h00000022, "r0_22");
    wait_idle("s2");
`ifdef TEXTLCD_BUSY_STALL_EN
    check("s2_lcd_cycles", 32'(e_rises - e0), 32'd2);
    check("s2_db", 32'(last_db), 32'h22);
    check("s2_rs", 32'(last_rs), 32'h0);
    rd_chk(5'h10, 32'h4, "s2_status_idle");
`else
    check("s2_lcd_cycles", 32'(e_rises - e0), 32'd1);
    check("s2_db", 32'(last_db), 32'h41);
    check("s2_rs", 32'(last_rs), 32'h1);
    rd_chk(5'h10, 32'h6, "s2_status_idle");
`endif
    check("s2_db_stable", 32'(db_glitch - g0), 32'd0);
    check("t_setup", 32'(t_e_rise - t_busy_rise), 32'd4);
    check("t_pulse", 32'(t_e_fall - t_e_rise), 32'd12);
    check("t_hold", 32'(t_busy_fall - t_e_fall), 32'd12);

    e0 = e_rises;
    wr(5'h00, 32'h80000030, 4'hF, "w30");
    rd_chk(5'h10, 32'h1, "ovr_clear_status");
    wait_idle("s3");
    check("s3_lcd_cycles", 32'(e_rises - e0), 32'd1);
    check("s3_db", 32'(last_db), 32'h30);
    check("s3_rs", 32'(last_rs), 32'h0);

    // REG0 write touching only byte 3 must not launch.
    e0 = e_rises;
    wr(5'h00, 32'h12000000, 4'b1000, "w_b3");
    repeat (5) @(posedge tb_ACLK);
    #1;
    check("b3_no_launch", 32'({lcd_busy, 8'(e_rises - e0)}), 32'h0);
    rd_chk(5'h00, 32'h12000030, "r0_b3");
    rd_chk(5'h10, 32'h4, "b3_status");

    // W leads AW by three cycles with a single byte lane.
    axi_write(5'h08, 32'h00AA0000, 4'b0100, 3, resp, lat, bvc, tmo);
    check("wlead_bresp", {29'b0, tmo, resp}, 32'h0);
    check("wlead_bv_pulses", 32'(bvc), 32'd1);
    check("wlead_bv_low", 32'(bvalid), 32'h0);
    rd_chk(5'h08, 32'hDEAA0011, "wlead_r2");

    // Unmapped and read-only addresses.
    rd_chk(5'h14, 32'h0, "r14");
    wr(5'h1C, 32'hFFFFFFFF, 4'hF, "w1c");
    rd_chk(5'h1C, 32'h0, "r1c");
    wr(5'h10, 32'hFFFFFFFF, 4'hF, "w_status");
    rd_chk(5'h10, 32'h4, "status_ro");
    rd_chk(5'h00, 32'h12000030, "keep_r0");
    rd_chk(5'h04, 32'hABCD0001, "keep_r1");
    rd_chk(5'h08, 32'hDEAA0011, "keep_r2");
    rd_chk(5'h0C, 32'hBEEF0011, "keep_r3");

    // Reset during the E pulse.
    wr(5'h00, 32'h00000155, 4'hF, "w155");
    wait_e_high("rst_mid");
    ARESET = 1'b1;
    @(posedge tb_ACLK); #1;
    check("rst_mid_lcd", 32'({lcd_e, lcd_busy, lcd_db}), 32'h0);
    ARESET = 1'b0;
    rd_chk(5'h00, 32'h0, "rst_mid_r0");
    rd_chk(5'h10, 32'h0, "rst_mid_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
